// File: rtl/read_burst_aligner.sv
// -----------------------------------------------------------------------------
// read_burst_aligner
//
// Realigns a burst of bus-aligned read beats so that the transfer starts at
// byte 0 of the first output beat. The first `shamt` bytes of the first input
// beat are discarded. Each output beat is built from the upper part of the
// previous input beat and the lower part of the current input beat. If the
// transfer's tail is still in the holding register after the last input beat,
// one extra registered flush beat is emitted.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   i_valid       input beat valid
//   i_start       first input beat of a burst (i_shamt / i_len sampled here)
//   i_end         last input beat of a burst
//   i_data        aligned read data, DATA_WIDTH bits
//   i_shamt       byte offset of the transfer within the first beat
//   i_len         transfer length in bytes (>= 1)
//   o_ready       beat accepted this cycle when i_valid is also high
//   o_valid       output beat valid
//   o_start       first output beat of the burst
//   o_end         last output beat of the burst
//   o_data        realigned data
//   o_be          byte enables of the output beat
//   o_idle        no burst in progress
// -----------------------------------------------------------------------------
module read_burst_aligner #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic                            i_start,
  input  logic                            i_end,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_shamt,
  input  logic [LEN_WIDTH-1:0]            i_len,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic                            o_start,
  output logic                            o_end,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [DATA_WIDTH/8-1:0]         o_be,
  output logic                            o_idle
);

  localparam int W  = DATA_WIDTH / 8;
  localparam int SW = $clog2(W);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_BODY  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_W   = LEN_WIDTH'(W);

  // Drop the leading s bytes; vacated upper bytes become zero.
  function automatic logic [DATA_WIDTH-1:0] head_f(
    input logic [DATA_WIDTH-1:0] x,
    input logic [SW-1:0]         s
  );
    return x >> {s, 3'b000};
  endfunction

  // Move the low s bytes of x to the top of the beat. s=0 contributes nothing
  // (a shift by the full width would otherwise be needed).
  function automatic logic [DATA_WIDTH-1:0] tail_f(
    input logic [DATA_WIDTH-1:0] x,
    input logic [SW-1:0]         s
  );
    logic [SW:0] nbytes;
    if (s == '0) begin
      return '0;
    end
    nbytes = (SW+1)'(W) - {1'b0, s};
    return x << {nbytes, 3'b000};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] held_reg, held_next;
  logic [SW-1:0]         shamt_reg, shamt_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  out_rem_reg, out_rem_next;
  // Set when the first output of the burst is still owed to S_BODY
  // (non-zero shift, multi-beat burst).
  logic                  first_reg, first_next;

  // ---------------------------------------------------------------------------
  // Derived values
  // ---------------------------------------------------------------------------
  logic                  ready_int;
  logic                  accept;
  logic [LEN_WIDTH:0]    len_round;
  logic [LEN_WIDTH-1:0]  out_total;
  logic [LEN_WIDTH-1:0]  end_len;
  logic [LEN_WIDTH-1:0]  end_rem;
  logic [W-1:0]          be_end;

  assign ready_int = (state_reg != S_FLUSH);
  assign accept    = i_valid && ready_int;

  // ceil(i_len / W), computed one bit wider so the rounding cannot overflow.
  assign len_round = {1'b0, i_len} + (LEN_WIDTH+1)'(W - 1);
  assign out_total = LEN_WIDTH'(len_round / (LEN_WIDTH+1)'(W));

  // The last-beat byte mask comes from i_len while still in S_START (the
  // single-beat case), otherwise from the latched length.
  assign end_len = (state_reg == S_START) ? i_len : len_reg;
  assign end_rem = end_len % LEN_W;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_be
      assign be_end[gi] = (end_rem == '0) || (end_rem > LEN_WIDTH'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and output datapath
  // ---------------------------------------------------------------------------
  logic                  out_valid;
  logic                  out_start;
  logic                  out_end;
  logic [DATA_WIDTH-1:0] out_data;

  always_comb begin
    state_next   = state_reg;
    held_next    = held_reg;
    shamt_next   = shamt_reg;
    len_next     = len_reg;
    out_rem_next = out_rem_reg;
    first_next   = first_reg;
    out_valid    = 1'b0;
    out_start    = 1'b0;
    out_end      = 1'b0;
    out_data     = '0;

    case (state_reg)
      S_START: begin
        // Beats without i_start are silently dropped here.
        if (accept && i_start) begin
          shamt_next   = i_shamt;
          len_next     = i_len;
          held_next    = i_data;
          out_rem_next = out_total;
          first_next   = 1'b0;
          if (i_shamt == '0) begin
            out_valid    = 1'b1;
            out_start    = 1'b1;
            out_end      = (out_total == LEN_ONE);
            out_data     = i_data;
            out_rem_next = out_total - LEN_ONE;
          end else if (i_end) begin
            out_valid = 1'b1;
            out_start = 1'b1;
            out_end   = 1'b1;
            out_data  = head_f(i_data, i_shamt);
          end else begin
            // Not enough bytes yet for a full output beat.
            first_next = 1'b1;
          end
          state_next = i_end ? S_START : S_BODY;
        end
      end

      S_BODY: begin
        if (accept) begin
          held_next    = i_data;
          out_valid    = 1'b1;
          out_start    = first_reg;
          first_next   = 1'b0;
          out_end      = (out_rem_reg == LEN_ONE);
          out_data     = (shamt_reg == '0) ? i_data
                                           : (head_f(held_reg, shamt_reg) |
                                              tail_f(i_data, shamt_reg));
          out_rem_next = out_rem_reg - LEN_ONE;
          if (i_end) begin
            // More than one output still owed means the tail sits in held_reg.
            state_next = (out_rem_reg > LEN_ONE) ? S_FLUSH : S_START;
          end
        end
      end

      S_FLUSH: begin
        out_valid    = 1'b1;
        out_start    = first_reg;
        out_end      = 1'b1;
        out_data     = head_f(held_reg, shamt_reg);
        first_next   = 1'b0;
        out_rem_next = '0;
        state_next   = S_START;
      end

      default: begin
        state_next = S_START;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_START;
      held_reg    <= '0;
      shamt_reg   <= '0;
      len_reg     <= '0;
      out_rem_reg <= '0;
      first_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      held_reg    <= held_next;
      shamt_reg   <= shamt_next;
      len_reg     <= len_next;
      out_rem_reg <= out_rem_next;
      first_reg   <= first_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: everything is forced quiet while rst is asserted, and all
  // qualifiers read zero whenever no beat is valid.
  // ---------------------------------------------------------------------------
  assign o_valid = out_valid && !rst;
  assign o_start = o_valid && out_start;
  assign o_end   = o_valid && out_end;
  assign o_data  = o_valid ? out_data : '0;
  assign o_be    = o_valid ? (out_end ? be_end : '1) : '0;
  assign o_ready = rst || ready_int;
  assign o_idle  = rst || ((state_reg == S_START) && !(i_valid && i_start));

endmodule
